// File: rtl/cpu_axi_bridge_v2_if.sv
// cpu_axi_bridge_v2_if: bundles the CPU SRAM-like request/response ports and the AXI3 master channels
// Ports (signals):
//   inst_*      instruction read request and responses (addr_ok, data_ok, rdata, rlast)
//   data_*      data read/write request and responses
//   ar*/r*      AXI3 read address and read data channels
//   aw*/w*/b*   AXI3 write address, write data and write response channels
// Modports: master = bridge side (answers the CPU, drives AXI), slave = environment side.
interface cpu_axi_bridge_v2_if #(
    parameter int ADDR_W  = 32,
    parameter int ID_W    = 4,
    parameter int MAX_LEN = 8
);
    localparam int LEN_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic [LEN_W-1:0]  inst_len;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [31:0]       inst_rdata;
    logic              inst_rlast;

    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic [LEN_W-1:0]  data_len;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;
    logic              data_rlast;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [1:0]        awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;

    logic [ID_W-1:0]   wid;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        input  inst_req, inst_addr, inst_len,
        output inst_addr_ok, inst_data_ok, inst_rdata, inst_rlast,
        input  data_req, data_wr, data_size, data_addr, data_wdata, data_len,
        output data_addr_ok, data_data_ok, data_rdata, data_rlast,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        output inst_req, inst_addr, inst_len,
        input  inst_addr_ok, inst_data_ok, inst_rdata, inst_rlast,
        output data_req, data_wr, data_size, data_addr, data_wdata, data_len,
        input  data_addr_ok, data_data_ok, data_rdata, data_rlast,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/cpu_axi_bridge_v2.sv
// cpu_axi_bridge_v2: SRAM-like CPU ports to AXI3 master with burst reads, per-port outstanding reads, posted writes
// Ports:
//   aclk_i     clock
//   aresetn_i  asynchronous active-low reset
//   bus        cpu_axi_bridge_v2_if.master (CPU inst/data ports and AXI3 master channels)
// Configuration: define BRIDGE_RAW_CHECK_EN to let data reads bypass a pending write unless they hit
// the same word; without it every data read waits for the write path to go idle.
module cpu_axi_bridge_v2 #(
    parameter int ADDR_W  = 32,
    parameter int ID_W    = 4,
    parameter int MAX_LEN = 8
) (
    input  logic                aclk_i,
    input  logic                aresetn_i,
    cpu_axi_bridge_v2_if.master bus
);
    localparam int LEN_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [ID_W-1:0] ID_INST = '0;
    localparam logic [ID_W-1:0] ID_DATA = ID_W'(1);

    typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R} rd_st_e;
    typedef enum logic [1:0] {WR_IDLE, WR_AWW, WR_ACK, WR_B} wr_st_e;

    rd_st_e ist_q, ist_d, dst_q, dst_d;
    wr_st_e wst_q, wst_d;
    logic aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [ADDR_W-1:0] ar_addr_q, aw_addr_q;
    logic [LEN_W-1:0] ar_len_q;
    logic [2:0] ar_size_q, aw_size_q, ar_size_new;
    logic [ID_W-1:0] ar_id_q;
    logic [31:0] w_data_q;
    logic [3:0] w_strb_q, strb;
    logic ar_busy, raw_ok, i_acc, d_rd_acc, d_wr_acc, i_beat, d_beat, aw_fin, w_fin;
    logic unused_ok;

    // The shared AR channel is owned by whichever port sits in RD_AR; only one can.
    assign ar_busy = ist_q == RD_AR || dst_q == RD_AR;
`ifdef BRIDGE_RAW_CHECK_EN
    assign raw_ok = wst_q == WR_IDLE || bus.data_addr[ADDR_W-1:2] != aw_addr_q[ADDR_W-1:2];
`else
    assign raw_ok = wst_q == WR_IDLE;
`endif
    assign d_rd_acc = bus.data_req && !bus.data_wr && dst_q == RD_IDLE && !ar_busy && raw_ok;
    assign d_wr_acc = bus.data_req && bus.data_wr && wst_q == WR_IDLE;
    // Data wins a same-cycle AR race.
    assign i_acc = bus.inst_req && ist_q == RD_IDLE && !ar_busy && !d_rd_acc;
    // Beats are honoured only while the port waits for them, so post-reset strays are drained silently.
    assign i_beat = bus.rvalid && bus.rid == ID_INST && ist_q == RD_R;
    assign d_beat = bus.rvalid && bus.rid == ID_DATA && dst_q == RD_R;
    assign aw_fin = aw_done_q || bus.awready;
    assign w_fin = w_done_q || bus.wready;
    assign strb = bus.data_size == 2'd0 ? 4'b0001 << bus.data_addr[1:0]
                : bus.data_size == 2'd1 ? (bus.data_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign ar_size_new = !d_rd_acc ? 3'd2 : bus.data_len != '0 ? 3'd2 : {1'b0, bus.data_size};
    assign unused_ok = ^{bus.rresp, bus.bresp, bus.bid};

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            ist_q     <= RD_IDLE;
            dst_q     <= RD_IDLE;
            wst_q     <= WR_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ar_addr_q <= '0;
            ar_len_q  <= '0;
            ar_size_q <= '0;
            ar_id_q   <= '0;
            aw_addr_q <= '0;
            aw_size_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            ist_q     <= ist_d;
            dst_q     <= dst_d;
            wst_q     <= wst_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            if (i_acc || d_rd_acc) begin
                ar_addr_q <= d_rd_acc ? bus.data_addr : bus.inst_addr;
                ar_len_q  <= d_rd_acc ? bus.data_len : bus.inst_len;
                ar_id_q   <= d_rd_acc ? ID_DATA : ID_INST;
                ar_size_q <= ar_size_new;
            end
            if (d_wr_acc) begin
                aw_addr_q <= bus.data_addr;
                aw_size_q <= {1'b0, bus.data_size};
                w_data_q  <= bus.data_wdata;
                w_strb_q  <= strb;
            end
        end
    end

    always_comb begin
        ist_d = ist_q == RD_IDLE ? (i_acc ? RD_AR : RD_IDLE)
              : ist_q == RD_AR ? (bus.arready ? RD_R : RD_AR)
              : (i_beat && bus.rlast ? RD_IDLE : RD_R);
        dst_d = dst_q == RD_IDLE ? (d_rd_acc ? RD_AR : RD_IDLE)
              : dst_q == RD_AR ? (bus.arready ? RD_R : RD_AR)
              : (d_beat && bus.rlast ? RD_IDLE : RD_R);
        // A slave may answer B in the ACK cycle already; bready is always high, so leave directly.
        wst_d = wst_q == WR_IDLE ? (d_wr_acc ? WR_AWW : WR_IDLE)
              : wst_q == WR_AWW ? (aw_fin && w_fin ? WR_ACK : WR_AWW)
              : (bus.bvalid ? WR_IDLE : WR_B);
        aw_done_d = wst_q == WR_AWW && aw_fin;
        w_done_d  = wst_q == WR_AWW && w_fin;
    end

    always_comb begin
        bus.inst_addr_ok = i_acc;
        bus.inst_data_ok = i_beat;
        bus.inst_rdata   = bus.rdata;
        bus.inst_rlast   = i_beat && bus.rlast;
        bus.data_addr_ok = d_rd_acc || d_wr_acc;
        bus.data_data_ok = d_beat || wst_q == WR_ACK;
        bus.data_rdata   = bus.rdata;
        bus.data_rlast   = d_beat && bus.rlast;
        bus.arid    = ar_id_q;
        bus.araddr  = ar_addr_q;
        bus.arlen   = 8'(ar_len_q);
        bus.arsize  = ar_size_q;
        bus.arburst = 2'b01;
        bus.arlock  = '0;
        bus.arcache = '0;
        bus.arprot  = '0;
        bus.arvalid = ar_busy;
        bus.rready  = 1'b1;
        bus.awid    = ID_DATA;
        bus.awaddr  = aw_addr_q;
        bus.awlen   = '0;
        bus.awsize  = aw_size_q;
        bus.awburst = 2'b01;
        bus.awlock  = '0;
        bus.awcache = '0;
        bus.awprot  = '0;
        bus.awvalid = wst_q == WR_AWW && !aw_done_q;
        bus.wid     = ID_DATA;
        bus.wdata   = w_data_q;
        bus.wstrb   = w_strb_q;
        bus.wlast   = 1'b1;
        bus.wvalid  = wst_q == WR_AWW && !w_done_q;
        bus.bready  = 1'b1;
    end
endmodule

// File: tb/tb_cpu_axi_bridge_v2.sv
// tb_cpu_axi_bridge_v2: directed stimulus with a queue scoreboard for the bridge's CPU responses
module tb_cpu_axi_bridge_v2;
    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    cpu_axi_bridge_v2_if #(.ADDR_W(32), .ID_W(4), .MAX_LEN(8)) bus ();
    cpu_axi_bridge_v2 #(.ADDR_W(32), .ID_W(4), .MAX_LEN(8)) dut (
        .aclk_i(clk),
        .aresetn_i(aresetn),
        .bus(bus)
    );

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } ar_t;

    int n_pass = 0;
    int n_chk = 0;
    logic [33:0] exp_i[$];
    logic [33:0] exp_d[$];
    ar_t ar_log[$];
    logic [33:0] ei, ed;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (aresetn && bus.inst_data_ok) begin
            if (exp_i.size() == 0) check("inst unexpected data_ok", 1, 0);
            else begin
                ei = exp_i.pop_front();
                check("inst rdata", bus.inst_rdata, ei[31:0]);
                check("inst rlast", bus.inst_rlast, ei[32]);
            end
        end
        if (aresetn && bus.data_data_ok) begin
            if (exp_d.size() == 0) check("data unexpected data_ok", 1, 0);
            else begin
                ed = exp_d.pop_front();
                if (ed[33]) check("write ack rlast", bus.data_rlast, 0);
                else begin
                    check("data rdata", bus.data_rdata, ed[31:0]);
                    check("data rlast", bus.data_rlast, ed[32]);
                end
            end
        end
        if (aresetn && bus.arvalid && bus.arready)
            ar_log.push_back(ar_t'{bus.arid, bus.araddr, bus.arlen, bus.arsize});
    end

    task automatic beat(input logic [3:0] id, input logic [31:0] d, input logic last);
        if (id == 4'd0) exp_i.push_back({1'b0, last, d});
        else exp_d.push_back({1'b0, last, d});
        bus.rvalid = 1'b1;
        bus.rid = id;
        bus.rdata = d;
        bus.rlast = last;
        tick();
        bus.rvalid = 1'b0;
        bus.rlast = 1'b0;
    endtask

    task automatic wait_ar(input string name, input ar_t exp);
        int n = 0;
        while (ar_log.size() == 0 && n < 20) begin
            tick();
            n++;
        end
        if (ar_log.size() == 0) check({name, " timeout"}, 0, 1);
        else check(name, ar_log.pop_front(), exp);
    endtask

    task automatic issue(input bit inst, input bit wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [2:0] len);
        bit got = 1'b0;
        if (inst) begin
            bus.inst_req = 1'b1;
            bus.inst_addr = addr;
            bus.inst_len = len;
        end else begin
            bus.data_req = 1'b1;
            bus.data_wr = wr;
            bus.data_size = size;
            bus.data_addr = addr;
            bus.data_wdata = wd;
            bus.data_len = len;
        end
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            got = inst ? bus.inst_addr_ok : bus.data_addr_ok;
            tick();
        end
        if (inst) bus.inst_req = 1'b0;
        else bus.data_req = 1'b0;
        if (!got) check("addr_ok timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.inst_req = 0; bus.inst_addr = 0; bus.inst_len = 0;
        bus.data_req = 0; bus.data_wr = 0; bus.data_size = 0; bus.data_addr = 0;
        bus.data_wdata = 0; bus.data_len = 0;
        bus.arready = 1; bus.rid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0; bus.rvalid = 0;
        bus.awready = 0; bus.wready = 0; bus.bid = 1; bus.bresp = 0; bus.bvalid = 0;
        #2;
        check("reset arvalid", bus.arvalid, 0);
        check("reset awvalid", bus.awvalid, 0);
        check("reset wvalid", bus.wvalid, 0);
        check("reset arlen", bus.arlen, 0);
        check("reset rready", bus.rready, 1);
        check("reset bready", bus.bready, 1);
        tick();
        tick();
        aresetn = 1'b1;

        // instruction single read
        issue(1, 0, 2'd0, 32'h1FC00000, 0, 3'd0);
        wait_ar("inst single AR", ar_t'{4'd0, 32'h1FC00000, 8'd0, 3'd2});
        beat(4'd0, 32'h3C080001, 1'b1);

        // data burst of 8 beats; size 0 must still give arsize 2
        issue(0, 0, 2'd0, 32'h00001000, 0, 3'd7);
        wait_ar("data burst AR", ar_t'{4'd1, 32'h00001000, 8'd7, 3'd2});
        for (int i = 0; i < 8; i++) beat(4'd1, 32'(i), i == 7);

        // simultaneous requests: data first, inst held off while arvalid is up
        bus.arready = 0;
        bus.inst_req = 1; bus.inst_addr = 32'h1FC00100; bus.inst_len = 3'd3;
        bus.data_req = 1; bus.data_wr = 0; bus.data_size = 2'd1; bus.data_addr = 32'h00002100; bus.data_len = 3'd0;
        @(negedge clk);
        check("race data_addr_ok", bus.data_addr_ok, 1);
        check("race inst_addr_ok", bus.inst_addr_ok, 0);
        tick();
        bus.data_req = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("inst stalled behind arvalid", bus.inst_addr_ok, 0);
            tick();
        end
        bus.arready = 1;
        @(negedge clk);
        check("inst stalled in AR handshake cycle", bus.inst_addr_ok, 0);
        tick();
        @(negedge clk);
        check("inst accepted after arvalid clears", bus.inst_addr_ok, 1);
        tick();
        bus.inst_req = 0;
        wait_ar("race data AR", ar_t'{4'd1, 32'h00002100, 8'd0, 3'd1});
        wait_ar("race inst AR", ar_t'{4'd0, 32'h1FC00100, 8'd3, 3'd2});
        beat(4'd0, 32'h11110000, 1'b0);
        beat(4'd1, 32'h22220000, 1'b1);
        beat(4'd0, 32'h11110001, 1'b0);
        beat(4'd0, 32'h11110002, 1'b0);
        beat(4'd0, 32'h11110003, 1'b1);

        // byte store, W handshake one cycle after AW
        bus.awready = 1; bus.wready = 0;
        exp_d.push_back({1'b1, 1'b0, 32'h0});
        issue(0, 1, 2'd0, 32'h00001003, 32'hAB000000, 3'd0);
        check("byte awvalid", bus.awvalid, 1);
        check("byte wvalid", bus.wvalid, 1);
        check("byte wstrb", bus.wstrb, 4'b1000);
        check("byte awsize", bus.awsize, 0);
        check("byte awaddr", bus.awaddr, 32'h00001003);
        check("byte wdata", bus.wdata, 32'hAB000000);
        tick();
        check("awvalid dropped after AW", bus.awvalid, 0);
        check("wvalid held until W", bus.wvalid, 1);
        check("no ack before W", bus.data_data_ok, 0);
        bus.wready = 1;
        tick();
        check("ack one cycle after W", bus.data_data_ok, 1);
        check("wvalid dropped after W", bus.wvalid, 0);
        bus.wready = 0;
        bus.data_req = 1; bus.data_wr = 1; bus.data_size = 2'd2; bus.data_addr = 32'h00001004;
        bus.data_wdata = 32'h12345678;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("second write stalled", bus.data_addr_ok, 0);
            tick();
        end
        bus.bvalid = 1;
        @(negedge clk);
        check("second write stalled on B cycle", bus.data_addr_ok, 0);
        tick();
        bus.bvalid = 0;
        bus.wready = 1;
        exp_d.push_back({1'b1, 1'b0, 32'h0});
        @(negedge clk);
        check("second write accepted after B", bus.data_addr_ok, 1);
        tick();
        bus.data_req = 0;
        check("word wstrb", bus.wstrb, 4'b1111);
        check("word awsize", bus.awsize, 2);
        tick();
        tick();
        bus.bvalid = 1;
        tick();
        bus.bvalid = 0;

        // read-after-write hazard with B pending on 0x2000
        exp_d.push_back({1'b1, 1'b0, 32'h0});
        issue(0, 1, 2'd1, 32'h00002000, 32'h0000BEEF, 3'd0);
        check("half wstrb", bus.wstrb, 4'b0011);
        tick();
        tick();
        bus.data_req = 1; bus.data_wr = 0; bus.data_size = 2'd2; bus.data_addr = 32'h00002004; bus.data_len = 3'd0;
        @(negedge clk);
`ifdef BRIDGE_RAW_CHECK_EN
        check("other-word read bypasses write", bus.data_addr_ok, 1);
        tick();
        bus.data_req = 0;
        wait_ar("bypass AR", ar_t'{4'd1, 32'h00002004, 8'd0, 3'd2});
        beat(4'd1, 32'hCAFE0004, 1'b1);
`else
        check("read stalls while write busy", bus.data_addr_ok, 0);
        tick();
        bus.data_req = 0;
`endif
        bus.data_req = 1; bus.data_size = 2'd1; bus.data_addr = 32'h00002002;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("same-word read stalls", bus.data_addr_ok, 0);
            tick();
        end
        bus.bvalid = 1;
        @(negedge clk);
        check("same-word read stalls on B cycle", bus.data_addr_ok, 0);
        tick();
        bus.bvalid = 0;
        @(negedge clk);
        check("same-word read accepted after B", bus.data_addr_ok, 1);
        tick();
        bus.data_req = 0;
        wait_ar("hazard AR", ar_t'{4'd1, 32'h00002002, 8'd0, 3'd1});
        beat(4'd1, 32'h0000BEEF, 1'b1);

        // reset in the middle of a burst
        issue(0, 0, 2'd2, 32'h00003000, 0, 3'd3);
        wait_ar("burst before reset AR", ar_t'{4'd1, 32'h00003000, 8'd3, 3'd2});
        beat(4'd1, 32'hA5A5A5A5, 1'b0);
        aresetn = 1'b0;
        #1;
        check("mid reset arvalid", bus.arvalid, 0);
        check("mid reset araddr", bus.araddr, 0);
        check("mid reset arlen", bus.arlen, 0);
        check("mid reset awvalid", bus.awvalid, 0);
        check("mid reset wvalid", bus.wvalid, 0);
        check("mid reset awaddr", bus.awaddr, 0);
        check("mid reset wdata", bus.wdata, 0);
        check("mid reset wstrb", bus.wstrb, 0);
        check("mid reset data_rlast", bus.data_rlast, 0);
        check("mid reset rready", bus.rready, 1);
        tick();
        tick();
        aresetn = 1'b1;
        bus.rvalid = 1; bus.rid = 4'd1; bus.rdata = 32'hDEAD0001; bus.rlast = 0;
        @(negedge clk);
        check("stray beat gives no data_ok", bus.data_data_ok, 0);
        tick();
        bus.rlast = 1; bus.rdata = 32'hDEAD0002;
        @(negedge clk);
        check("stray last beat gives no data_ok", bus.data_data_ok, 0);
        tick();
        bus.rvalid = 0; bus.rlast = 0;
        bus.bvalid = 1;
        @(negedge clk);
        check("stray bvalid gives no data_ok", bus.data_data_ok, 0);
        tick();
        bus.bvalid = 0;

        // normal operation after reset
        issue(0, 0, 2'd2, 32'h00004000, 0, 3'd0);
        wait_ar("post-reset AR", ar_t'{4'd1, 32'h00004000, 8'd0, 3'd2});
        beat(4'd1, 32'h44444444, 1'b1);
        tick();
        tick();
        check("inst responses drained", exp_i.size(), 0);
        check("data responses drained", exp_d.size(), 0);
        check("AR log drained", ar_log.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cpu_axi_bridge_v2.md
# cpu_axi_bridge_v2

Parametrised successor of the core's SRAM-like-to-AXI3 bridge, sitting between `mips_core` (after `mmu` translation) and the top-level AXI master ports. It adds burst reads (cache-line refill), independent outstanding reads on the instruction and data ports, and posted single-beat data writes. Read-after-write ordering on the data port is protected by a hazard check.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `ID_W`, 4, AXI ID width; instruction reads use ID 0, data reads and writes use ID 1
- `MAX_LEN`, 8, maximum beats per read burst (power of two, 1..16); `LEN_W = $clog2(MAX_LEN)` (minimum 1)

Ports:
- `aclk` in 1: clock; single clock domain
- `aresetn` in 1: reset, asynchronous, active-low
- `inst_req` in 1, `inst_addr` in ADDR_W, `inst_len` in LEN_W (beats-1): instruction read request
- `inst_addr_ok` out 1, `inst_data_ok` out 1, `inst_rdata` out 32, `inst_rlast` out 1: instruction port responses
- `data_req` in 1, `data_wr` in 1, `data_size` in 2, `data_addr` in ADDR_W, `data_wdata` in 32, `data_len` in LEN_W: data request; `data_len` is ignored when `data_wr`=1
- `data_addr_ok` out 1, `data_data_ok` out 1, `data_rdata` out 32, `data_rlast` out 1: data port responses
- AXI3 master: `arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid/arready`, `rid/rdata/rresp/rlast/rvalid/rready`, `awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid/awready`, `wid/wdata/wstrb/wlast/wvalid/wready`, `bid/bresp/bvalid/bready`, with standard widths and `arlen/awlen` set to 8 bits

## Operation
- Constant outputs: `arburst`=`awburst`=2'b01 (INCR); `arlock`, `arcache`, `arprot`, `awlock`, `awcache`, `awprot` = 0; `awlen`=0; `awid`=`wid`=1; `wlast`=1; `rready`=`bready`=1.
- Per-port read FSM, for instruction and data independently: IDLE -> AR (arvalid owned) -> R (awaiting beats) -> IDLE after the beat with `rlast`. At most one outstanding read per port.
- AR arbitration: a request is accepted only if its port FSM is IDLE and the shared AR channel is free (no `arvalid` held). If both ports request in the same cycle, the data port wins.
- `arlen` = latched len. `arsize` = 2 when len>0, otherwise `data_size` for data reads and 2 for instruction reads.
- Beat routing: `rvalid` with `rid`=0 drives `inst_data_ok`, `inst_rdata`, `inst_rlast`; `rid`=1 drives the data-port equivalents. `rdata` and `rlast` pass through combinationally. `rresp` is ignored.
- Write FSM: IDLE -> AWW (`awvalid` and `wvalid` raised together, each dropped independently on its handshake) -> ACK (one-cycle `data_data_ok`) -> B (awaiting `bvalid`) -> IDLE. A new write is accepted only in IDLE.
- `wstrb`: size 0 -> 1<<addr[1:0]; size 1 -> addr[1] ? 4'b1100 : 4'b0011; size 2 -> 4'b1111. `awsize`=`data_size`.
- Data port: only one of a read or a write may be accepted per cycle. A data read may be accepted while the write FSM is in ACK or B, subject to the hazard rule in Configuration.

## Timing
- `*_addr_ok` is combinational: it is high in the cycle `req` is accepted. All request fields are latched on that edge.
- `arvalid`/`awvalid`/`wvalid` rise on the edge after acceptance and hold, with stable payload, until their handshakes complete.
- Minimum read latency: accept at cycle 0, AR at cycle 1, first `data_ok` in the cycle `rvalid` is seen (cycle 2 or later with a zero-wait slave).
- Write: `data_data_ok` pulses one cycle after the later of the AW and W handshakes. B completion is silent.
- Reset values: all valid, ok, and last outputs are 0; `araddr`/`awaddr`/`wdata`/`wstrb`/`arlen` are 0; `rready`/`bready` are 1. All FSMs go to IDLE.
- Reset asserted mid-transaction discards all outstanding state. Stray `rvalid`/`bvalid` beats after reset are drained via `rready`/`bready`=1 and never produce `data_ok`.

## Configuration
- `BRIDGE_RAW_CHECK_EN` defined: a data read issued while the write FSM is not IDLE is accepted unless addr[ADDR_W-1:2] matches the pending write's word address. On a match, `data_addr_ok` stays low until the write FSM returns to IDLE.
- `BRIDGE_RAW_CHECK_EN` undefined: every data read stalls while the write FSM is not IDLE.

## Test plan
- Instruction single read to 0x1FC00000, len 0: `arlen`=0, `arsize`=2, `arid`=0; rdata 0x3C080001 -> one `inst_data_ok` with `inst_rlast`=1.
- Data burst, len 7, to 0x00001000: 8 `data_data_ok` pulses returning 0..7 in order, `data_rlast` on beat 8 only, `arsize`=2.
- Simultaneous inst and data requests: data AR is issued first and `inst_addr_ok` stays low until `arvalid` clears. Responses interleaved by `rid` are routed correctly.
- Byte store 0xAB at 0x1003: `wstrb`=4'b1000, `awsize`=0, `data_data_ok` one cycle after both handshakes. With `bvalid` delayed 10 cycles, a second write's `data_addr_ok` stays low for those 10 cycles.
- With `BRIDGE_RAW_CHECK_EN` and B pending on 0x2000: a read of 0x2004 is accepted immediately, and a read of 0x2002 stalls until B. With the macro undefined, both reads stall.
- `aresetn` asserted during an R burst: all outputs return to reset values, and late beats produce no `data_ok`.
